// File: rtl/farm_sensor_conditioner.sv
// Conditions the raw farm-road loop detector: synchroniser, arrival qualifier and departure stretcher.
// Define STUCK_DETECT_EN to add the stuck-loop fault state and the stuck output.
module farm_sensor_conditioner #(
    parameter int SYNC_STAGES  = 2,
    parameter int QUAL_CYCLES  = 8,
    parameter int HOLD_CYCLES  = 16,
    parameter int STUCK_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       loop_raw,
    output logic       sensor,
    output logic       vehicle_pulse,
    output logic [7:0] vehicle_count,
    output logic       stuck
);

    localparam int QW = $clog2(QUAL_CYCLES + 1);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam logic [QW-1:0] QUAL_LAST = QW'(QUAL_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES);

    if (SYNC_STAGES < 2 || QUAL_CYCLES < 2 || HOLD_CYCLES < 1 || STUCK_CYCLES < 2) begin : g_param_check
        $error("farm_sensor_conditioner: parameter outside legal range");
    end

    typedef enum logic [2:0] {
        IDLE,
        QUALIFY,
        PRESENT,
`ifdef STUCK_DETECT_EN
        HOLD,
        FAULT
`else
        HOLD
`endif
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   loop_s;
    state_t                 state_q;
    logic [QW-1:0]          qcnt_q;
    logic [HW-1:0]          hcnt_q;
    logic                   sensor_q;
    logic                   pulse_q;
    logic [7:0]             count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], loop_raw};
        end
    end

    assign loop_s = sync_q[SYNC_STAGES-1];

`ifdef STUCK_DETECT_EN
    localparam int SW = $clog2(STUCK_CYCLES + 1);
    localparam logic [SW-1:0] STUCK_LAST = SW'(STUCK_CYCLES - 1);
    logic [SW-1:0] scnt_q;
    logic          stuck_q;
`endif

    // The pulse and count change only on QUALIFY->PRESENT so a vehicle that briefly
    // drops out during HOLD is never counted twice.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            qcnt_q   <= '0;
            hcnt_q   <= '0;
            sensor_q <= 1'b0;
            pulse_q  <= 1'b0;
            count_q  <= '0;
`ifdef STUCK_DETECT_EN
            scnt_q   <= '0;
            stuck_q  <= 1'b0;
`endif
        end else begin
            pulse_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (loop_s) begin
                        state_q <= QUALIFY;
                        qcnt_q  <= QW'(1);
                    end
                end
                QUALIFY: begin
                    if (!loop_s) begin
                        state_q <= IDLE;
                        qcnt_q  <= '0;
                    end else if (qcnt_q == QUAL_LAST) begin
                        state_q  <= PRESENT;
                        qcnt_q   <= '0;
                        sensor_q <= 1'b1;
                        pulse_q  <= 1'b1;
                        if (count_q != 8'hFF) begin
                            count_q <= count_q + 8'd1;
                        end
                    end else begin
                        qcnt_q <= qcnt_q + QW'(1);
                    end
                end
                PRESENT: begin
                    if (!loop_s) begin
                        state_q <= HOLD;
                        hcnt_q  <= HW'(1);
`ifdef STUCK_DETECT_EN
                        scnt_q  <= '0;
                    end else if (scnt_q == STUCK_LAST) begin
                        state_q <= FAULT;
                        scnt_q  <= '0;
                        stuck_q <= 1'b1;
                    end else begin
                        scnt_q <= scnt_q + SW'(1);
`endif
                    end
                end
                HOLD: begin
                    if (loop_s) begin
                        state_q <= PRESENT;
                        hcnt_q  <= '0;
                    end else if (hcnt_q == HOLD_LAST) begin
                        state_q  <= IDLE;
                        hcnt_q   <= '0;
                        sensor_q <= 1'b0;
                    end else begin
                        hcnt_q <= hcnt_q + HW'(1);
                    end
                end
`ifdef STUCK_DETECT_EN
                // Sensor stays high while faulted so farm traffic is never stranded.
                FAULT: begin
                    if (!loop_s) begin
                        state_q  <= IDLE;
                        sensor_q <= 1'b0;
                        stuck_q  <= 1'b0;
                    end
                end
`endif
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign sensor        = sensor_q;
    assign vehicle_pulse = pulse_q;
    assign vehicle_count = count_q;
`ifdef STUCK_DETECT_EN
    assign stuck         = stuck_q;
`else
    assign stuck         = 1'b0;
`endif

endmodule
